// File: rtl/multi_channel_duration_timer.sv
// Per-channel high-pulse width timer with last/count/accumulated/max statistics and a snapshot readout bank.
// Edge detection lags trigger by SYNC_STAGES+1 clocks; reads return one clock after read_strobe; no backpressure.
module multi_channel_duration_timer #(
  parameter int NUMBER_OF_CHANNELS   = 4,
  parameter int COUNTER_WIDTH        = 32,
  parameter int SYNC_STAGES          = 3,
  parameter int CHANNEL_SELECT_WIDTH = 2
) (
  input  logic                            clock,
  input  logic                            reset_active_low,
  input  logic                            enable,
  input  logic [NUMBER_OF_CHANNELS-1:0]   trigger,
  input  logic                            snapshot,
  input  logic                            clear_on_snapshot,
  input  logic                            read_strobe,
  input  logic [CHANNEL_SELECT_WIDTH-1:0] read_channel,
  input  logic [1:0]                      read_field,
  output logic [COUNTER_WIDTH-1:0]        read_data,
  output logic                            read_valid,
  output logic                            snapshot_done,
  output logic [NUMBER_OF_CHANNELS-1:0]   level,
  output logic [NUMBER_OF_CHANNELS-1:0]   overflow
);

  localparam int N = NUMBER_OF_CHANNELS;
  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] MAX_VALUE = {W{1'b1}};
  localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, BLOCKED = 2'd2} state_t;

  logic [N-1:0] sync_chain [SYNC_STAGES];
  logic [N-1:0] prev_level;
  logic [N-1:0] rise, fall, commit, count_full, acc_carry, dur_sat, overflow_set;
  state_t       state       [N];
  logic [W-1:0] duration    [N];
  logic [W-1:0] last_dur    [N];
  logic [W-1:0] pulse_count [N];
  logic [W-1:0] acc_dur     [N];
  logic [W-1:0] max_dur     [N];
  logic [W-1:0] bank        [N][4];
  logic [W:0]   acc_sum     [N];
  logic [W-1:0] read_word;
  logic         clearing;

  assign level    = sync_chain[SYNC_STAGES-1];
  assign clearing = snapshot & clear_on_snapshot;

  always_comb begin
    rise         = level & ~prev_level;
    fall         = ~level & prev_level;
    commit       = '0;
    count_full   = '0;
    acc_carry    = '0;
    dur_sat      = '0;
    overflow_set = '0;
    read_word    = '0;
    for (int ch = 0; ch < N; ch++) begin
      acc_sum[ch]      = {1'b0, acc_dur[ch]} + {1'b0, duration[ch]};
      commit[ch]       = (state[ch] == HIGH) && fall[ch];
      count_full[ch]   = (pulse_count[ch] == MAX_VALUE);
      acc_carry[ch]    = acc_sum[ch][W];
      dur_sat[ch]      = (state[ch] == HIGH) && level[ch] && enable && (duration[ch] == MAX_VALUE);
      // A seeded commit during a clearing snapshot starts from zero and cannot saturate.
      overflow_set[ch] = dur_sat[ch] | (commit[ch] & ~clearing & (count_full[ch] | acc_carry[ch]));
      if (int'(read_channel) == ch) read_word = bank[ch][read_field];
    end
  end

  always_ff @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
      prev_level    <= '0;
      overflow      <= '0;
      read_data     <= '0;
      read_valid    <= 1'b0;
      snapshot_done <= 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        state[ch]       <= IDLE;
        duration[ch]    <= '0;
        last_dur[ch]    <= '0;
        pulse_count[ch] <= '0;
        acc_dur[ch]     <= '0;
        max_dur[ch]     <= '0;
        for (int f = 0; f < 4; f++) bank[ch][f] <= '0;
      end
    end else begin
      sync_chain[0] <= trigger;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
      prev_level    <= level;
      snapshot_done <= snapshot;
      read_valid    <= read_strobe;
      if (read_strobe) read_data <= read_word;

      for (int ch = 0; ch < N; ch++) begin
        if (snapshot) begin
          bank[ch][0] <= last_dur[ch];
          bank[ch][1] <= pulse_count[ch];
          bank[ch][2] <= acc_dur[ch];
          bank[ch][3] <= max_dur[ch];
        end
        overflow[ch] <= (overflow[ch] & ~clearing) | overflow_set[ch];

        case (state[ch])
          IDLE: begin
            if (rise[ch]) begin
              if (enable) begin
                state[ch]    <= HIGH;
                duration[ch] <= ONE;
              end else begin
                state[ch] <= BLOCKED;
              end
            end
          end
          HIGH: begin
            if (fall[ch]) begin
              state[ch]    <= IDLE;
              duration[ch] <= '0;
            end else if (enable && !dur_sat[ch]) begin
              duration[ch] <= duration[ch] + ONE;
            end
          end
          BLOCKED: begin
            if (fall[ch]) state[ch] <= IDLE;
          end
          default: state[ch] <= IDLE;
        endcase

        if (clearing) begin
          last_dur[ch]    <= commit[ch] ? duration[ch] : '0;
          pulse_count[ch] <= commit[ch] ? ONE : '0;
          acc_dur[ch]     <= commit[ch] ? duration[ch] : '0;
          max_dur[ch]     <= commit[ch] ? duration[ch] : '0;
        end else if (commit[ch]) begin
          last_dur[ch]    <= duration[ch];
          pulse_count[ch] <= count_full[ch] ? MAX_VALUE : pulse_count[ch] + ONE;
          acc_dur[ch]     <= acc_carry[ch] ? MAX_VALUE : acc_sum[ch][W-1:0];
          max_dur[ch]     <= (duration[ch] > max_dur[ch]) ? duration[ch] : max_dur[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_duration_timer.sv
// Bench for multi_channel_duration_timer: directed scenarios with fixed expected values,
// then random traffic compared every cycle against a pulse-level reference model.
module tb_multi_channel_duration_timer;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int S    = 3;
  localparam int CSW  = 3;
  localparam int MAXV = 255;

  logic           clock = 1'b0;
  logic           reset_active_low = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   trigger = '0;
  logic           snapshot = 1'b0;
  logic           clear_on_snapshot = 1'b0;
  logic           read_strobe = 1'b0;
  logic [CSW-1:0] read_channel = '0;
  logic [1:0]     read_field = '0;
  logic [W-1:0]   read_data;
  logic           read_valid;
  logic           snapshot_done;
  logic [N-1:0]   level;
  logic [N-1:0]   overflow;

  int total = 0;
  int bad   = 0;

  multi_channel_duration_timer #(
    .NUMBER_OF_CHANNELS(N), .COUNTER_WIDTH(W), .SYNC_STAGES(S), .CHANNEL_SELECT_WIDTH(CSW)
  ) dut (
    .clock(clock), .reset_active_low(reset_active_low), .enable(enable), .trigger(trigger),
    .snapshot(snapshot), .clear_on_snapshot(clear_on_snapshot), .read_strobe(read_strobe),
    .read_channel(read_channel), .read_field(read_field), .read_data(read_data),
    .read_valid(read_valid), .snapshot_done(snapshot_done), .level(level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: trigger history, per-pulse bookkeeping, statistics and bank as plain ints.
  logic [N-1:0] hist[$];
  bit           m_act [N];
  bit           m_blk [N];
  bit           m_ovf [N];
  int           m_dur [N];
  int           m_last[N];
  int           m_cnt [N];
  int           m_acc [N];
  int           m_max [N];
  int           m_bank[N][4];
  int           exp_rd = 0;
  bit           exp_rv = 0;
  bit           exp_sd = 0;
  logic [N-1:0] cur_lv, old_lv, exp_ovf;
  bit           did_commit, dur_ovf;
  int           cval;

  // Level seen by the timer i clocks back in sampled trigger history.
  function automatic logic [N-1:0] hv(input int i);
    return (i < hist.size()) ? hist[i] : '0;
  endfunction

  always @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      hist.delete();
      exp_rd = 0; exp_rv = 0; exp_sd = 0;
      for (int ch = 0; ch < N; ch++) begin
        m_act[ch] = 0; m_blk[ch] = 0; m_ovf[ch] = 0; m_dur[ch] = 0;
        m_last[ch] = 0; m_cnt[ch] = 0; m_acc[ch] = 0; m_max[ch] = 0;
        for (int f = 0; f < 4; f++) m_bank[ch][f] = 0;
      end
    end else begin
      cur_lv = hv(S-1);
      old_lv = hv(S);
      exp_rv = read_strobe;
      if (read_strobe) begin
        exp_rd = 0;
        if (int'(read_channel) < N) exp_rd = m_bank[read_channel][read_field];
      end
      exp_sd = snapshot;
      if (snapshot)
        for (int ch = 0; ch < N; ch++) begin
          m_bank[ch][0] = m_last[ch]; m_bank[ch][1] = m_cnt[ch];
          m_bank[ch][2] = m_acc[ch];  m_bank[ch][3] = m_max[ch];
        end
      for (int ch = 0; ch < N; ch++) begin
        did_commit = 0; dur_ovf = 0; cval = 0;
        if (m_act[ch]) begin
          if (!cur_lv[ch]) begin
            did_commit = 1; cval = m_dur[ch]; m_act[ch] = 0; m_dur[ch] = 0;
          end else if (enable) begin
            if (m_dur[ch] == MAXV) dur_ovf = 1; else m_dur[ch]++;
          end
        end else if (m_blk[ch]) begin
          if (!cur_lv[ch]) m_blk[ch] = 0;
        end else if (cur_lv[ch] && !old_lv[ch]) begin
          if (enable) begin m_act[ch] = 1; m_dur[ch] = 1; end
          else m_blk[ch] = 1;
        end
        if (snapshot && clear_on_snapshot) begin
          m_ovf[ch]  = 0;
          m_last[ch] = cval; m_acc[ch] = cval; m_max[ch] = cval;
          m_cnt[ch]  = did_commit ? 1 : 0;
        end else if (did_commit) begin
          m_last[ch] = cval;
          if (m_cnt[ch] == MAXV) m_ovf[ch] = 1; else m_cnt[ch]++;
          if (m_acc[ch] + cval > MAXV) begin m_acc[ch] = MAXV; m_ovf[ch] = 1; end
          else m_acc[ch] += cval;
          if (cval > m_max[ch]) m_max[ch] = cval;
        end
        if (dur_ovf) m_ovf[ch] = 1;
      end
      hist.push_front(trigger);
      while (hist.size() > S + 1) void'(hist.pop_back());
    end
  end

  always @(negedge clock) begin
    if (reset_active_low) begin
      for (int ch = 0; ch < N; ch++) exp_ovf[ch] = m_ovf[ch];
      check_value("level", 32'(level), 32'(hv(S-1)));
      check_value("overflow", 32'(overflow), 32'(exp_ovf));
      check_value("read_valid", 32'(read_valid), 32'(exp_rv));
      check_value("read_data", 32'(read_data), exp_rd);
      check_value("snapshot_done", 32'(snapshot_done), 32'(exp_sd));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int ch, input int len);
    @(negedge clock); trigger[ch] = 1'b1;
    repeat (len) @(negedge clock);
    trigger[ch] = 1'b0;
    idle(S + 3);
  endtask

  task automatic snap(input bit clr);
    @(negedge clock); snapshot = 1'b1; clear_on_snapshot = clr;
    @(negedge clock); snapshot = 1'b0; clear_on_snapshot = 1'b0;
    check_value("snap_done_pulse", 32'(snapshot_done), 1);
  endtask

  task automatic read_word(input int ch, input int f, input int want, input string tag);
    @(negedge clock); read_strobe = 1'b1; read_channel = CSW'(ch); read_field = 2'(f);
    @(negedge clock); read_strobe = 1'b0;
    check_value({tag, "_valid"}, 32'(read_valid), 1);
    check_value(tag, 32'(read_data), want);
  endtask

  initial begin
    idle(3);
    check_value("rst_read_data", 32'(read_data), 0);
    check_value("rst_level", 32'(level), 0);
    check_value("rst_overflow", 32'(overflow), 0);
    @(negedge clock); #1 reset_active_low = 1'b1; enable = 1'b1;
    idle(2);

    // Single 100-cycle pulse on channel 0.
    pulse(0, 100);
    snap(0);
    read_word(0, 0, 100, "t1_last");
    read_word(0, 1, 1,   "t1_count");
    read_word(0, 2, 100, "t1_acc");
    read_word(0, 3, 100, "t1_max");

    // Three pulses on channel 1 after restarting statistics.
    snap(1);
    pulse(1, 10); pulse(1, 30); pulse(1, 20);
    snap(0);
    read_word(1, 0, 20, "t2_last");
    read_word(1, 1, 3,  "t2_count");
    read_word(1, 2, 60, "t2_acc");
    read_word(1, 3, 30, "t2_max");
    read_word(0, 1, 0,  "t2_ch0_count");
    read_word(2, 1, 0,  "t2_ch2_count");
    read_word(3, 2, 0,  "t2_ch3_acc");

    // Pulse that begins while disabled is never recorded.
    snap(1);
    @(negedge clock); enable = 1'b0; trigger[2] = 1'b1;
    idle(10); enable = 1'b1;
    idle(10); trigger[2] = 1'b0;
    idle(S + 3);
    snap(0);
    read_word(2, 1, 0, "t3_blocked_count");
    pulse(2, 5);
    snap(0);
    read_word(2, 1, 1, "t3_count");
    read_word(2, 0, 5, "t3_last");

    // Saturation on channel 3.
    pulse(3, 300);
    check_value("t4_ovf_set", 32'(overflow[3]), 1);
    snap(0);
    read_word(3, 0, MAXV, "t4_last_sat");
    snap(1);
    check_value("t4_ovf_clr", 32'(overflow[3]), 0);
    snap(0);
    read_word(3, 1, 0, "t4_count_cleared");

    // Commit landing in the same cycle as a clearing snapshot.
    snap(1);
    @(negedge clock); trigger[0] = 1'b1;
    repeat (7) @(negedge clock);
    trigger[0] = 1'b0;
    repeat (S) @(negedge clock);
    snapshot = 1'b1; clear_on_snapshot = 1'b1;
    @(negedge clock); snapshot = 1'b0; clear_on_snapshot = 1'b0;
    idle(2);
    read_word(0, 1, 0, "t5_bank_excl");
    snap(0);
    read_word(0, 1, 1, "t5_count");
    read_word(0, 0, 7, "t5_last");
    read_word(0, 2, 7, "t5_acc");
    read_word(0, 3, 7, "t5_max");

    // Out-of-range channel, then reset in the middle of a pulse.
    read_word(5, 0, 0, "t6_oob_last");
    read_word(7, 1, 0, "t6_oob_count");
    read_word(0, 1, 1, "t6_pre_reset");
    @(negedge clock); trigger[1] = 1'b1;
    idle(20);
    #1 reset_active_low = 1'b0;
    #1;
    check_value("t6_rst_read_data", 32'(read_data), 0);
    check_value("t6_rst_read_valid", 32'(read_valid), 0);
    check_value("t6_rst_snap_done", 32'(snapshot_done), 0);
    check_value("t6_rst_level", 32'(level), 0);
    check_value("t6_rst_overflow", 32'(overflow), 0);
    @(negedge clock); trigger = '0;
    idle(3);
    @(negedge clock); #1 reset_active_low = 1'b1;
    idle(S + 5);
    snap(0);
    read_word(1, 1, 0, "t6_no_commit_count");
    read_word(1, 0, 0, "t6_no_commit_last");

    // Random traffic; the per-cycle comparisons against the model do the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, (ch == 3) ? 350 : 12) == 0) trigger[ch] = ~trigger[ch];
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      snapshot          = ($urandom_range(0, 30) == 0);
      clear_on_snapshot = 1'($urandom_range(0, 1));
      read_strobe       = ($urandom_range(0, 2) == 0);
      read_channel      = CSW'($urandom_range(0, 7));
      read_field        = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    trigger = '0; snapshot = 1'b0; clear_on_snapshot = 1'b0; read_strobe = 1'b0; enable = 1'b1;
    idle(S + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_duration_timer.md
Name: multi_channel_duration_timer

Overview:
Parametrised successor to the single-channel trigger duration timer. It measures high-pulse widths on NUMBER_OF_CHANNELS asynchronous trigger inputs in units of the fast clock. Per channel it keeps last duration, pulse count, accumulated duration and maximum duration. A snapshot copies all channels into a readout bank that the UART/display formatting logic reads one word at a time.

Parameters:
NUMBER_OF_CHANNELS, 4, number of independent trigger inputs (1..16)
COUNTER_WIDTH, 32, width of every duration/count/accumulator register
SYNC_STAGES, 3, synchronizer flops per trigger input (>=2)
CHANNEL_SELECT_WIDTH, 2, width of read_channel; 2**CHANNEL_SELECT_WIDTH >= NUMBER_OF_CHANNELS

Ports:
clock  input  1  fast measurement clock (PLL output)
reset_active_low  input  1  asynchronous, active-low reset
enable  input  1  measurement gate (tie to pll_is_locked); low = no arming, counters frozen
trigger  input  NUMBER_OF_CHANNELS  asynchronous trigger levels
snapshot  input  1  single-cycle request to copy live registers into the readout bank
clear_on_snapshot  input  1  sampled with snapshot; 1 = restart live statistics
read_strobe  input  1  single-cycle read request
read_channel  input  CHANNEL_SELECT_WIDTH  channel to read
read_field  input  2  0=last duration, 1=pulse count, 2=accumulated duration, 3=max duration
read_data  output  COUNTER_WIDTH  selected bank word
read_valid  output  1  one-cycle pulse, read_data updated
snapshot_done  output  1  one-cycle pulse, bank loaded
level  output  NUMBER_OF_CHANNELS  synchronized trigger levels (for LEDs)
overflow  output  NUMBER_OF_CHANNELS  sticky per-channel saturation flags

Behaviour:
- Reset (asynchronous, reset_active_low=0): all live registers, bank, synchronizers, state, and outputs go to 0. Channel states go to IDLE.
- Synchronizer: each trigger bit passes through SYNC_STAGES flops. level = last stage. Rise = prev level 0 and level 1. Fall = prev level 1 and level 0.
- Per-channel FSM:
  - IDLE: on rise with enable=1 -> HIGH with duration=1. On rise with enable=0 -> BLOCKED.
  - HIGH: duration increments by 1 each cycle while level=1 and enable=1. It holds while enable=0.
  - HIGH on fall: last<=duration, count+=1, acc+=duration, max<=max(max,duration), duration<=0 -> IDLE. This commit happens regardless of enable.
  - BLOCKED: on fall -> IDLE with no commit. Partial pulses are never recorded.
- Arithmetic: all registers are unsigned and saturate at 2**COUNTER_WIDTH-1, never wrap. Any saturation sets overflow[ch]. overflow is cleared only by reset or by a clearing snapshot.
- Snapshot (cycle S):
  - The bank loads every channel's pre-update register values (values held at start of S).
  - snapshot_done pulses in S+1.
  - With clear_on_snapshot=1, live last/count/acc/max/overflow restart at 0. A commit in cycle S seeds them instead: count=1, last=acc=max=duration. The in-progress duration and FSM state are never cleared.
- Readout:
  - read_strobe in cycle R registers channel/field from the bank.
  - read_data and read_valid appear in R+1. Latency is 1.
  - read_data holds until the next strobe.
  - read_channel >= NUMBER_OF_CHANNELS returns 0 with read_valid=1.
  - Read and snapshot in the same cycle: the read returns the old bank contents.
- Channels are fully independent. Simultaneous edges on all channels are all committed in the same cycle.

Test Plan:
- Reset, enable=1, channel 0 held high 100 cycles (clean edges), snapshot, read field 0/1/2/3 -> 100, 1, 100, 100; read_valid one cycle after each strobe.
- Channel 1 pulses of 10, 30, 20 cycles, snapshot -> last=20, count=3, acc=60, max=30; channels 0,2,3 read 0.
- Channel 2 rises while enable=0, enable raised mid-pulse, then falls -> count stays 0. Next pulse of 5 cycles with enable=1 -> count=1, last=5.
- COUNTER_WIDTH=8, channel 3 high 300 cycles -> last=255, overflow[3]=1. Clearing snapshot -> overflow[3]=0 and a later snapshot reads count=0.
- Commit on channel 0 (duration 7) in the same cycle as snapshot with clear_on_snapshot=1 -> bank excludes it. Next snapshot shows count=1, last=acc=max=7.
- read_channel=5 with NUMBER_OF_CHANNELS=4 and CHANNEL_SELECT_WIDTH=3 -> read_data=0. Assert reset mid-pulse -> all outputs 0 immediately and no commit after release.
